// File: rtl/fios_pkg.sv
// Shared definitions for the FIOS multiplier back end: word width, pointer
// sizing helpers and the result-reducer state encoding.
package fios_pkg;

  localparam int WORD_W = 17;

  // Bits needed to index s words (at least 1, so a one-word build still has a port).
  function automatic int word_ptr_w(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

  // Bits needed to count 0..s words inclusive.
  function automatic int word_cnt_w(input int s);
    return $clog2(s + 1);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SUB,
    SEL,
    OUT
  } reducer_state_t;

endpackage

// File: rtl/fios_result_reducer_if.sv
// Result-reducer bus: multiplier result push, p-store read port, output stream
// and status. master is the reducer side, slave the surrounding system.
interface fios_result_reducer_if
  import fios_pkg::*;
#(
  parameter int S = 8,
  parameter int W = WORD_W
);

  localparam int PTR_W = word_ptr_w(S);

  logic             res_push_i;
  logic [W-1:0]     res_i;
  logic             done_i;
  logic [PTR_W-1:0] p_addr_o;
  logic             p_rd_en_o;
  logic [W-1:0]     p_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [W-1:0]     out_data_o;
  logic             out_last_o;
  logic             busy_o;
  logic             error_o;

  modport master (
    input  res_push_i, res_i, done_i, p_i, out_ready_i,
    output p_addr_o, p_rd_en_o, out_valid_o, out_data_o, out_last_o, busy_o, error_o
  );

  modport slave (
    output res_push_i, res_i, done_i, p_i, out_ready_i,
    input  p_addr_o, p_rd_en_o, out_valid_o, out_data_o, out_last_o, busy_o, error_o
  );

endinterface

// File: rtl/fios_word_subtractor.sv
// One radix-2^W digit of a word-serial subtraction: combinational difference,
// borrow held in a register between digits.
module fios_word_subtractor #(
  parameter int W = 17
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         borrow_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W:0] full;
  logic       borrow_q, borrow_d;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    full     = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, borrow_i};
    diff_o   = full[W-1:0];
    borrow_d = borrow_q;
    if (clr_i) begin
      borrow_d = 1'b0;
    end else if (en_i) begin
      borrow_d = full[W];
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      borrow_q <= 1'b0;
    end else begin
      borrow_q <= borrow_d;
    end
  end

  assign borrow_o = borrow_q;

endmodule

// File: rtl/fios_result_reducer.sv
// Captures the multiplier's result words, conditionally subtracts p word-serially
// and streams the reduced result out on a valid/ready port.
module fios_result_reducer
  import fios_pkg::*;
#(
  parameter int S = 8,
  parameter int W = WORD_W
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  fios_result_reducer_if.master bus
);

  localparam int                PTR_W    = word_ptr_w(S);
  localparam int                CNT_W    = word_cnt_w(S);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(S);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(S - 1);

  reducer_state_t   state_q, state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] out_ptr_q, out_ptr_d;
  logic             sel_res_q, sel_res_d;
  logic             error_q, error_d;
  logic [W-1:0]     res_buf_q  [S];
  logic [W-1:0]     res_buf_d  [S];
  logic [W-1:0]     diff_buf_q [S];
  logic [W-1:0]     diff_buf_d [S];

  logic [CNT_W-1:0] push_cnt;
  logic [PTR_W-1:0] sub_idx;
  logic             sub_en, sub_clr, borrow;
  logic [W-1:0]     diff;

  // SUB cycle k (k >= 1) consumes the p word requested in cycle k-1.
  assign sub_idx = PTR_W'(rd_ptr_q - CNT_W'(1));

  fios_word_subtractor #(.W(W)) u_sub (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clr_i    (sub_clr),
    .en_i     (sub_en),
    .a_i      (res_buf_q[sub_idx]),
    .b_i      (bus.p_i),
    .borrow_i (borrow),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_ptr_d   = out_ptr_q;
    sel_res_d   = sel_res_q;
    error_d     = error_q;
    res_buf_d   = res_buf_q;
    diff_buf_d  = diff_buf_q;
    push_cnt    = wr_ptr_q;
    sub_en      = 1'b0;
    sub_clr     = 1'b0;
    bus.p_rd_en_o   = 1'b0;
    bus.p_addr_o    = '0;
    bus.out_valid_o = 1'b0;
    bus.out_data_o  = '0;
    bus.out_last_o  = 1'b0;
    bus.busy_o      = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (bus.res_push_i) begin
          if (wr_ptr_q == FULL_CNT) begin
            error_d = 1'b1;
          end else begin
            res_buf_d[wr_ptr_q[PTR_W-1:0]] = bus.res_i;
            push_cnt = wr_ptr_q + CNT_W'(1);
            state_d  = COLLECT;
          end
        end
        wr_ptr_d = push_cnt;
        // done_i sees the word count including a push in the same cycle.
        if (bus.done_i) begin
          if (push_cnt == FULL_CNT) begin
            state_d  = SUB;
            rd_ptr_d = '0;
            sub_clr  = 1'b1;
          end else begin
            error_d  = 1'b1;
            wr_ptr_d = '0;
            state_d  = IDLE;
          end
        end
      end

      SUB: begin
        bus.busy_o = 1'b1;
        if (rd_ptr_q != FULL_CNT) begin
          bus.p_rd_en_o = 1'b1;
          bus.p_addr_o  = rd_ptr_q[PTR_W-1:0];
          rd_ptr_d      = rd_ptr_q + CNT_W'(1);
        end else begin
          state_d = SEL;
        end
        if (rd_ptr_q != '0) begin
          sub_en              = 1'b1;
          diff_buf_d[sub_idx] = diff;
        end
      end

      SEL: begin
        bus.busy_o = 1'b1;
        sel_res_d  = borrow;
        out_ptr_d  = '0;
        state_d    = OUT;
      end

      OUT: begin
        bus.busy_o      = 1'b1;
        bus.out_valid_o = 1'b1;
        bus.out_data_o  = sel_res_q ? res_buf_q[out_ptr_q] : diff_buf_q[out_ptr_q];
        bus.out_last_o  = (out_ptr_q == LAST_PTR);
        if (bus.out_ready_i) begin
          if (out_ptr_q == LAST_PTR) begin
            state_d   = IDLE;
            wr_ptr_d  = '0;
            out_ptr_d = '0;
          end else begin
            out_ptr_d = out_ptr_q + PTR_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if ((state_q == SUB || state_q == SEL || state_q == OUT) &&
        (bus.res_push_i || bus.done_i)) begin
      error_d = 1'b1;
    end
  end

  assign bus.error_o = error_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_ptr_q <= '0;
      sel_res_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      out_ptr_q <= out_ptr_d;
      sel_res_q <= sel_res_d;
      error_q   <= error_d;
    end
  end

  // NOTE: the word buffers have no reset; clearing the pointers discards their contents.
  always_ff @(posedge clock_i) begin
    res_buf_q  <= res_buf_d;
    diff_buf_q <= diff_buf_d;
  end

endmodule
